// File: rtl/mux_sel_stager.sv
// mux_sel_stager: two single-entry operand holding slots (A and B) feeding a
// registered a/b/sel output stage that drives a downstream 2:1 mux. One word
// issues per cycle at most; ties between full slots are broken round-robin.
module mux_sel_stager #(
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      issue_cnt
);

  // Channel index 0 is A, index 1 is B throughout.
  logic [WIDTH-1:0] in_data  [2];
  logic [WIDTH-1:0] hold_vec [2];
  logic [1:0]       in_valid;
  logic [1:0]       full_vec;
  logic [1:0]       ready_vec;
  logic [1:0]       issue_vec;
  logic             slot_free;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sel_reg;
  logic             out_valid_reg;
  logic             last_grant_reg;  // 1 = B was granted last, so A wins the next tie
  logic [15:0]      issue_cnt_reg;

  assign in_data[0] = a_in;
  assign in_data[1] = b_in;
  assign in_valid   = {b_valid, a_valid};

  // The output stage can take a new word when empty or being drained this cycle.
  assign slot_free = !out_valid_reg || out_ready;

  // Pick at most one full slot to issue; both full -> the one not granted last.
  always_comb begin
    issue_vec = 2'b00;
    if (slot_free) begin
      if (full_vec == 2'b11) begin
        issue_vec = last_grant_reg ? 2'b01 : 2'b10;
      end else begin
        issue_vec = full_vec;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic             full_reg;
      logic [WIDTH-1:0] hold_reg;

      // A slot being issued this cycle can be refilled in the same cycle.
      assign ready_vec[gi] = !full_reg || issue_vec[gi];
      assign full_vec[gi]  = full_reg;
      assign hold_vec[gi]  = hold_reg;

      // Holding slot: capture on accept, empty on issue unless refilled.
      always_ff @(posedge clk) begin
        if (reset) begin
          full_reg <= 1'b0;
          hold_reg <= '0;
        end else if (in_valid[gi] && ready_vec[gi]) begin
          full_reg <= 1'b1;
          hold_reg <= in_data[gi];
        end else if (issue_vec[gi]) begin
          full_reg <= 1'b0;
        end
      end
    end
  endgenerate

  // Output stage: load the issued operand onto its own mux leg, keep the other
  // leg untouched, and hold everything while the downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg          <= '0;
      b_reg          <= '0;
      sel_reg        <= 1'b0;
      out_valid_reg  <= 1'b0;
      last_grant_reg <= 1'b1;
      issue_cnt_reg  <= 16'd0;
    end else begin
      if (issue_vec[0]) begin
        a_reg          <= hold_vec[0];
        sel_reg        <= 1'b0;
        last_grant_reg <= 1'b0;
      end else if (issue_vec[1]) begin
        b_reg          <= hold_vec[1];
        sel_reg        <= 1'b1;
        last_grant_reg <= 1'b1;
      end

      if (|issue_vec) begin
        out_valid_reg <= 1'b1;
        issue_cnt_reg <= issue_cnt_reg + 16'd1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign a_ready   = ready_vec[0];
  assign b_ready   = ready_vec[1];
  assign a         = a_reg;
  assign b         = b_reg;
  assign sel       = sel_reg;
  assign out_valid = out_valid_reg;
  assign issue_cnt = issue_cnt_reg;

endmodule
